// File: rtl/spart_driver.sv
// spart_driver
//   Bus-side controller for the SPART serial port. After reset it writes the
//   baud divisor (low byte, then high byte). It then echoes every received byte
//   back to the transmitter. It re-programs the divisor whenever br_cfg changes
//   while the loop is idle in WAIT_RX.
//
// Ports
//   clk, rst     system clock, asynchronous active-high reset
//   br_cfg[1:0]  baud select (00=4800, 01=9600, 10=19200, 11=38400)
//   rda, tbr     SPART status: receive data available, transmit buffer ready
//   iocs, iorw   bus chip select (one-cycle strobe) and direction (1 = read)
//   ioaddr[1:0]  00 tx/rx buffer, 01 status, 10 divisor low, 11 divisor high
//   databus[7:0] bidirectional; driven only during write strobes
//   rx_data[7:0] last byte read from the SPART
//   cfg_done     divisor programmed for the current setting
//
// State table
//   state    | meaning
//   INIT_LO  | write divisor low byte, capture br_cfg
//   INIT_HI  | write divisor high byte
//   WAIT_RX  | idle, waiting for rda or a br_cfg change
//   READ_RX  | read the rx buffer
//   WAIT_TX  | hold the byte until tbr
//   WRITE_TX | write the byte back to the tx buffer
module spart_driver #(
  parameter logic [15:0] DIV_4800  = 16'd1042,
  parameter logic [15:0] DIV_9600  = 16'd521,
  parameter logic [15:0] DIV_19200 = 16'd260,
  parameter logic [15:0] DIV_38400 = 16'd130
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic [7:0] rx_data,
  output logic       cfg_done
);

  typedef enum logic [2:0] {
    INIT_LO  = 3'd0,
    INIT_HI  = 3'd1,
    WAIT_RX  = 3'd2,
    READ_RX  = 3'd3,
    WAIT_TX  = 3'd4,
    WRITE_TX = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        run_q;
  logic [1:0]  cfg_q, cfg_d;
  logic [15:0] div_sel;
  logic        iocs_q, iorw_q;
  logic [1:0]  ioaddr_q;
  logic [7:0]  dout_q;
  logic [7:0]  rx_q;
  logic        cfg_done_q;

  function automatic logic [15:0] div_of(input logic [1:0] sel);
    case (sel)
      2'b00:   div_of = DIV_4800;
      2'b01:   div_of = DIV_9600;
      2'b10:   div_of = DIV_19200;
      default: div_of = DIV_38400;
    endcase
  endfunction

  // The first edge after reset only arms run_q. This holds the machine in
  // INIT_LO so that the registered bus outputs present INIT_LO for the whole
  // first cycle after release.
  always_comb begin
    state_d = state_q;
    if (!run_q) begin
      state_d = INIT_LO;
    end else begin
      case (state_q)
        INIT_LO:  state_d = INIT_HI;
        INIT_HI:  state_d = WAIT_RX;
        WAIT_RX: begin
          if (br_cfg != cfg_q) state_d = INIT_LO;
          else if (rda)        state_d = READ_RX;
        end
        READ_RX:  state_d = WAIT_TX;
        WAIT_TX:  if (tbr) state_d = WRITE_TX;
        WRITE_TX: state_d = WAIT_RX;
        default:  state_d = INIT_LO;
      endcase
    end
  end

  // INIT_LO is only ever entered, never held. Capturing br_cfg on the entry
  // edge therefore ties both divisor bytes of a pass to one setting.
  assign cfg_d   = (state_d == INIT_LO) ? br_cfg : cfg_q;
  assign div_sel = div_of(cfg_d);

  // Bus outputs are loaded from the decode of the next state, so they are
  // flops that track the state register exactly one-for-one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT_LO;
      run_q      <= 1'b0;
      cfg_q      <= 2'b00;
      iocs_q     <= 1'b0;
      iorw_q     <= 1'b1;
      ioaddr_q   <= 2'b00;
      dout_q     <= 8'h00;
      rx_q       <= 8'h00;
      cfg_done_q <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      cfg_q   <= cfg_d;
      if (run_q && state_q == READ_RX) rx_q <= databus;
      cfg_done_q <= !(state_d == INIT_LO || state_d == INIT_HI);
      case (state_d)
        INIT_LO: begin
          iocs_q   <= 1'b1;
          iorw_q   <= 1'b0;
          ioaddr_q <= 2'b10;
          dout_q   <= div_sel[7:0];
        end
        INIT_HI: begin
          iocs_q   <= 1'b1;
          iorw_q   <= 1'b0;
          ioaddr_q <= 2'b11;
          dout_q   <= div_sel[15:8];
        end
        READ_RX: begin
          iocs_q   <= 1'b1;
          iorw_q   <= 1'b1;
          ioaddr_q <= 2'b00;
          dout_q   <= 8'h00;
        end
        WRITE_TX: begin
          iocs_q   <= 1'b1;
          iorw_q   <= 1'b0;
          ioaddr_q <= 2'b00;
          dout_q   <= rx_q;
        end
        default: begin
          iocs_q   <= 1'b0;
          iorw_q   <= 1'b1;
          ioaddr_q <= 2'b00;
          dout_q   <= 8'h00;
        end
      endcase
    end
  end

  assign iocs     = iocs_q;
  assign iorw     = iorw_q;
  assign ioaddr   = ioaddr_q;
  assign rx_data  = rx_q;
  assign cfg_done = cfg_done_q;
  assign databus  = (iocs_q && !iorw_q) ? dout_q : 8'hzz;

endmodule

// File: doc/spart_driver.md
# spart_driver

Bus-side controller for the SPART serial port. After reset it programs the SPART baud divisor through the I/O bus. It then runs a continuous echo loop: wait for received data, read the byte, wait for transmitter ready, write the byte back. It is the only master on the SPART I/O bus (`iocs`, `iorw`, `ioaddr`, `databus`) and re-programs the divisor whenever the baud-select input changes.

## Interface
- `DIV_4800`, default 16'd1042: divisor for `br_cfg`=00
- `DIV_9600`, default 16'd521: divisor for `br_cfg`=01
- `DIV_19200`, default 16'd260: divisor for `br_cfg`=10
- `DIV_38400`, default 16'd130: divisor for `br_cfg`=11

- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  asynchronous, active-high reset
- `br_cfg`  in  2  baud select (static switches; treated as synchronous)
- `rda`  in  1  SPART read data available
- `tbr`  in  1  SPART transmit buffer ready
- `iocs`  out  1  I/O chip select; one-cycle strobe per bus access
- `iorw`  out  1  1 = read, 0 = write
- `ioaddr`  out  2  00 = tx/rx buffer, 01 = status, 10 = divisor low byte, 11 = divisor high byte
- `databus`  inout  8  driven only when `iocs`=1 and `iorw`=0; otherwise high-Z
- `rx_data`  out  8  last byte read from SPART (debug)
- `cfg_done`  out  1  high once the divisor has been programmed for the current `br_cfg`

## Operation
- States: INIT_LO, INIT_HI, WAIT_RX, READ_RX, WAIT_TX, WRITE_TX.
- Bus outputs are Moore-decoded from the state register.
  - All bus outputs are registered state decodes. No combinational path from `rda`/`tbr` to bus outputs.
- INIT_LO:
  - Bus: `iocs`=1, `iorw`=0, `ioaddr`=10, `databus` = divisor[7:0].
  - Captures `br_cfg` into `cfg_q`.
  - Next: INIT_HI unconditionally.
- INIT_HI:
  - Bus: `iocs`=1, `iorw`=0, `ioaddr`=11, `databus` = divisor[15:8].
  - Next: WAIT_RX.
- Divisor selection:
  - Divisor is selected from `cfg_q`, captured in INIT_LO.
  - Both bytes of one programming pass always come from the same setting.
- WAIT_RX:
  - Bus: `iocs`=0.
  - If `br_cfg` != `cfg_q`, go to INIT_LO. This check has priority over `rda`.
  - Else if `rda`=1, go to READ_RX.
  - Else stay.
- READ_RX:
  - Bus: `iocs`=1, `iorw`=1, `ioaddr`=00, `databus` high-Z.
  - `databus` is sampled into `rx_data` at the clock edge ending this state.
  - Next: WAIT_TX.
- WAIT_TX:
  - Bus: `iocs`=0.
  - If `tbr`=1, go to WRITE_TX; else stay.
  - A `br_cfg` change here is ignored until WAIT_RX. The echo completes at the old rate.
- WRITE_TX:
  - Bus: `iocs`=1, `iorw`=0, `ioaddr`=00, `databus` = `rx_data`.
  - Next: WAIT_RX.
- Idle bus values (`iocs`=0): `iorw`=1, `ioaddr`=00, `databus` high-Z.
- `cfg_done`:
  - Set on the edge leaving INIT_HI.
  - Cleared on entry to INIT_LO and by reset.
- Reset mid-operation:
  - Any in-flight access is abandoned.
  - Bus returns to idle immediately (asynchronous).
  - Re-initialisation starts from INIT_LO.

## Timing
- Reset values:
  - State = INIT_LO (bus outputs are not driven while `rst`=1).
  - `iocs`=0, `iorw`=1, `ioaddr`=00, `databus` high-Z, `rx_data`=8'h00, `cfg_done`=0.
- After reset deasserts:
  - INIT_LO occupies the first `clk` cycle.
  - INIT_HI occupies the second.
  - `cfg_done`=1 from the third cycle.
- Every bus access is exactly one cycle wide. There are never back-to-back `iocs` cycles, except INIT_LO→INIT_HI.
- Minimum echo latency: `rda` sampled high at edge N → READ_RX in cycle N+1 → WRITE_TX in cycle N+3, provided `tbr`=1 at edge N+2.
- `rda` held high across WRITE_TX is re-evaluated in WAIT_RX. The SPART clears `rda` on the read, so no double read occurs.
- Reconfiguration: a `br_cfg` change seen in WAIT_RX takes two cycles of bus writes. `cfg_done` is low for exactly those two cycles.

## Test plan
- Reset release, `br_cfg`=01 → cycle 1: `ioaddr`=10, `databus`=8'h09; cycle 2: `ioaddr`=11, `databus`=8'h02; then `cfg_done`=1 and `iocs`=0.
- In WAIT_RX, pulse `rda`; drive `databus`=8'hA5 during the read cycle; hold `tbr`=1 → one read at `ioaddr`=00, `rx_data`=8'hA5, then a write of 8'hA5 to `ioaddr`=00 two cycles after the read.
- Same as above with `tbr`=0 for 20 cycles after the read → `iocs` stays 0 throughout; the write occurs the cycle after `tbr` rises.
- Change `br_cfg` 01→11 while idle in WAIT_RX → writes of 8'h82 then 8'h00; `cfg_done` low for 2 cycles.
- Change `br_cfg` during WAIT_TX → echo write completes first, then the divisor is reprogrammed with the new value.
- Assert `rst` during WAIT_TX → `iocs`=0 and `databus` high-Z immediately; after release, INIT_LO/INIT_HI repeat and `rx_data`=8'h00.
